game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
Top-level game sequencer for the Flappy Bird datapath. It gates the frame tick that advances the obstacles and bird, and issues the reload pulse for obstacles and score. On collision it freezes play and commits the final score to the 32-entry score RAM. It then scans the RAM to publish the top three scores for the HEX display.

Parameters:
TICK_DIV, 500000, CLOCK_50 cycles per game frame (100 Hz)
SCORE_W, 11, score / RAM data width
ADDR_W, 5, RAM address width; depth = 2**ADDR_W (32)
OVER_HOLD, 200, frames in OVER during which start is ignored

Ports:
clk  in  1  CLOCK_50 system clock
reset  in  1  asynchronous, active-high reset
start  in  1  synchronised user press (level); only rising edges act
collision  in  1  collision flag from collision unit
score  in  SCORE_W  live score from score counter
mem_rdata  in  SCORE_W  RAM read data, 1-cycle synchronous latency
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  SCORE_W  RAM write data
mem_we  out  1  RAM write enable
game_tick  out  1  1-cycle frame pulse, PLAY only
obs_load  out  1  1-cycle pulse: reload obstacles and clear score
playing  out  1  high in PLAY
game_over  out  1  high in OVER
busy  out  1  high in SAVE and SCAN
best0, best1, best2  out  SCORE_W each  top-3 scores, best0 largest

Behaviour:
- Reset (async): state IDLE. All outputs 0. Tick counter, hold counter, wr_ptr, valid_cnt and shadow bests are 0. RAM contents are not cleared; valid_cnt masks stale entries.
- start_edge = start & ~start_q. start_q is a register, reset value 0.
- IDLE: start_edge -> LOAD.
- LOAD: exactly 1 cycle. obs_load=1, tick counter cleared. Next state PLAY.
- PLAY: playing=1. Tick counter runs 0..TICK_DIV-1 and wraps. game_tick=1 in the cycle the counter equals TICK_DIV-1.
  - collision=1 -> SAVE; score latched to score_q in that same cycle.
  - If collision and tick-terminal coincide, game_tick is suppressed.
  - start is ignored.
- SAVE: exactly 1 cycle. mem_we=1, mem_addr=wr_ptr, mem_wdata=score_q.
  - wr_ptr increments modulo 2**ADDR_W (31 -> 0).
  - valid_cnt increments and saturates at 32.
  - Shadow bests cleared. Next state SCAN, scan address 0.
- SCAN: issues addresses 0..valid_cnt-1, one per cycle; mem_we=0.
  - Each returned word d is inserted into the shadow bests one cycle after its address is issued:
    - d>s0: s2<=s1, s1<=s0, s0<=d
    - else d>s1: s2<=s1, s1<=d
    - else d>s2: s2<=d
    - strict compares; an equal value drops to the next slot, so duplicates are kept.
  - SCAN lasts valid_cnt+1 cycles.
  - In the final cycle, best0..2 are loaded from the shadow registers atomically. They hold their old values throughout SCAN.
  - Next state OVER.
- OVER: game_over=1.
  - Hold counter counts OVER_HOLD frames of TICK_DIV cycles each, internally; game_tick stays 0.
  - start_edge during the hold is ignored. After the hold, start_edge -> LOAD.
- collision is ignored outside PLAY.
- Reset in any state, including mid-SAVE or mid-SCAN, returns to IDLE with mem_we=0 immediately. Partial scan results are discarded.
- Widths: counters sized with $clog2 of their terminal values. valid_cnt is ADDR_W+1 bits.

Test Plan:
Unless stated, TICK_DIV=4, OVER_HOLD=2.
1. Reset, then start rises at cycle n -> obs_load=1 only in cycle n+1; playing from n+2; game_tick at n+5, n+9, n+13.
2. In PLAY, collision=1 with score=7 -> next cycle mem_we=1, addr=0, data=7. Then addr 0 read, and after 2 SCAN cycles best0=7, best1=0, best2=0, game_over=1.
3. Three games with scores 5, 9, 9 (each restarted after the hold) -> best0=9, best1=9, best2=5. Writes land at addresses 0, 1, 2.
4. 33 games with scores 1..33 -> the 33rd write goes to addr 0 with data 33. valid_cnt stays at 32; SCAN issues 32 reads (33 cycles); bests are 33, 32, 31.
5. start pulsed 3 cycles into OVER -> ignored. start pulsed after 8 cycles of OVER -> obs_load one cycle later.
6. Reset asserted during SCAN -> state IDLE the same cycle: mem_we=0, busy=0, best0..2=0, wr_ptr=0. A following start is accepted normally.

Source files
------------

// File: rtl/game_flow_if.sv
// Handshake and RAM bundle between the game sequencer and its datapath.
// The sequencer uses the slave view; the board top or bench uses master.
interface game_flow_if #(
  parameter int SCORE_W = 11,
  parameter int ADDR_W  = 5
);
  logic               start;
  logic               collision;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] mem_rdata;
  logic [ADDR_W-1:0]  mem_addr;
  logic [SCORE_W-1:0] mem_wdata;
  logic               mem_we;
  logic               game_tick;
  logic               obs_load;
  logic               playing;
  logic               game_over;
  logic               busy;
  logic [SCORE_W-1:0] best0;
  logic [SCORE_W-1:0] best1;
  logic [SCORE_W-1:0] best2;

  modport master (
    output start, collision, score, mem_rdata,
    input  mem_addr, mem_wdata, mem_we,
    input  game_tick, obs_load, playing,
    input  game_over, busy,
    input  best0, best1, best2
  );

  modport slave (
    input  start, collision, score, mem_rdata,
    output mem_addr, mem_wdata, mem_we,
    output game_tick, obs_load, playing,
    output game_over, busy,
    output best0, best1, best2
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Flappy Bird game sequencer: frame tick gating, score save to RAM,
// and a RAM scan that publishes the top three scores.
module game_flow_ctrl #(
  parameter int TICK_DIV  = 500000,
  parameter int SCORE_W   = 11,
  parameter int ADDR_W    = 5,
  parameter int OVER_HOLD = 200
) (
  input  logic       clk,
  input  logic       reset,
  game_flow_if.slave gf
);
  localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW    = $clog2(OVER_HOLD + 1);
  localparam int VW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(OVER_HOLD);
  localparam logic [VW-1:0] VALID_MAX = VW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PLAY, S_SAVE, S_SCAN, S_OVER
  } state_t;

  state_t             state_q, state_d;
  logic               start_q;
  logic [TW-1:0]      tick_q, tick_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [VW-1:0]      valid_q, valid_d;
  logic [VW-1:0]      scan_q, scan_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] s0_q, s1_q, s2_q;
  logic [SCORE_W-1:0] s0_d, s1_d, s2_d;
  logic [SCORE_W-1:0] b0_q, b1_q, b2_q;
  logic [SCORE_W-1:0] b0_d, b1_d, b2_d;
  logic [SCORE_W-1:0] i0, i1, i2;
  logic [SCORE_W-1:0] rd;
  logic               start_edge;
  logic               tick_term;
  logic               hold_done;

  logic [ADDR_W-1:0]  addr_c;
  logic [SCORE_W-1:0] wdata_c;
  logic               we_c, tick_c, load_c;
  logic               play_c, over_c, busy_c;

  assign rd         = gf.mem_rdata;
  assign start_edge = gf.start & ~start_q;
  assign tick_term  = (tick_q == TICK_LAST);
  assign hold_done  = (hold_q == HOLD_LAST);

  // Insert the returned RAM word into the shadow top-3 (ties drop down).
  always_comb begin
    i0 = s0_q;
    i1 = s1_q;
    i2 = s2_q;
    if (rd > s0_q) begin
      i2 = s1_q;
      i1 = s0_q;
      i0 = rd;
    end else if (rd > s1_q) begin
      i2 = s1_q;
      i1 = rd;
    end else if (rd > s2_q) begin
      i2 = rd;
    end
  end

  // Next-state and output decode for the game sequencer.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    hold_d   = hold_q;
    wr_ptr_d = wr_ptr_q;
    valid_d  = valid_q;
    scan_d   = scan_q;
    score_d  = score_q;
    s0_d     = s0_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    b0_d     = b0_q;
    b1_d     = b1_q;
    b2_d     = b2_q;
    addr_c   = '0;
    wdata_c  = '0;
    we_c     = 1'b0;
    tick_c   = 1'b0;
    load_c   = 1'b0;
    play_c   = 1'b0;
    over_c   = 1'b0;
    busy_c   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start_edge) state_d = S_LOAD;
      end
      S_LOAD: begin
        load_c  = 1'b1;
        tick_d  = '0;
        state_d = S_PLAY;
      end
      S_PLAY: begin
        play_c = 1'b1;
        tick_d = tick_term ? '0 : tick_q + 1'b1;
        if (gf.collision) begin
          score_d = gf.score;
          state_d = S_SAVE;
        end else begin
          tick_c = tick_term;
        end
      end
      S_SAVE: begin
        busy_c   = 1'b1;
        we_c     = 1'b1;
        addr_c   = wr_ptr_q;
        wdata_c  = score_q;
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (valid_q != VALID_MAX) valid_d = valid_q + 1'b1;
        s0_d    = '0;
        s1_d    = '0;
        s2_d    = '0;
        scan_d  = '0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        busy_c = 1'b1;
        if (scan_q < valid_q) addr_c = scan_q[ADDR_W-1:0];
        if (scan_q != '0) begin
          s0_d = i0;
          s1_d = i1;
          s2_d = i2;
        end
        if (scan_q == valid_q) begin
          b0_d    = i0;
          b1_d    = i1;
          b2_d    = i2;
          tick_d  = '0;
          hold_d  = '0;
          state_d = S_OVER;
        end else begin
          scan_d = scan_q + 1'b1;
        end
      end
      S_OVER: begin
        over_c = 1'b1;
        if (!hold_done) begin
          tick_d = tick_term ? '0 : tick_q + 1'b1;
          if (tick_term) hold_d = hold_q + 1'b1;
        end else if (start_edge) begin
          state_d = S_LOAD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any save or scan.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      tick_q   <= '0;
      hold_q   <= '0;
      wr_ptr_q <= '0;
      valid_q  <= '0;
      scan_q   <= '0;
      score_q  <= '0;
      s0_q     <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      b0_q     <= '0;
      b1_q     <= '0;
      b2_q     <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= gf.start;
      tick_q   <= tick_d;
      hold_q   <= hold_d;
      wr_ptr_q <= wr_ptr_d;
      valid_q  <= valid_d;
      scan_q   <= scan_d;
      score_q  <= score_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      b0_q     <= b0_d;
      b1_q     <= b1_d;
      b2_q     <= b2_d;
    end
  end

  assign gf.mem_addr  = addr_c;
  assign gf.mem_wdata = wdata_c;
  assign gf.mem_we    = we_c;
  assign gf.game_tick = tick_c;
  assign gf.obs_load  = load_c;
  assign gf.playing   = play_c;
  assign gf.game_over = over_c;
  assign gf.busy      = busy_c;
  assign gf.best0     = b0_q;
  assign gf.best1     = b1_q;
  assign gf.best2     = b2_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: RAM model, write/result scoreboards,
// directed game sequences with a short frame and hold.
module tb_game_flow_ctrl;
  localparam int SW    = 11;
  localparam int AW    = 5;
  localparam int TD    = 4;
  localparam int OH    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  game_flow_if #(.SCORE_W(SW), .ADDR_W(AW)) gf ();

  game_flow_ctrl #(
    .TICK_DIV(TD), .SCORE_W(SW),
    .ADDR_W(AW), .OVER_HOLD(OH)
  ) dut (
    .clk(clk), .reset(reset), .gf(gf)
  );

  logic [SW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (gf.mem_we) ram[gf.mem_addr] <= gf.mem_wdata;
    gf.mem_rdata <= ram[gf.mem_addr];
  end

  typedef struct packed {
    logic [AW-1:0] a;
    logic [SW-1:0] d;
  } wr_t;

  typedef struct packed {
    logic [SW-1:0] b0;
    logic [SW-1:0] b1;
    logic [SW-1:0] b2;
    logic [7:0]    len;
  } res_t;

  wr_t  wr_q[$];
  res_t res_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [SW-1:0] mram [DEPTH];
  int mptr = 0;
  int mvalid = 0;

  task automatic expect_game(input int sc);
    int   q[$];
    wr_t  w;
    res_t r;
    w.a = AW'(mptr);
    w.d = SW'(sc);
    wr_q.push_back(w);
    mram[mptr] = SW'(sc);
    mptr = (mptr + 1) % DEPTH;
    if (mvalid < DEPTH) mvalid++;
    for (int i = 0; i < mvalid; i++) q.push_back(int'(mram[i]));
    q.rsort();
    r.b0  = SW'(q[0]);
    r.b1  = (q.size() > 1) ? SW'(q[1]) : '0;
    r.b2  = (q.size() > 2) ? SW'(q[2]) : '0;
    r.len = 8'(mvalid + 2);
    res_q.push_back(r);
  endtask

  logic          pb = 1'b0;
  int            blen = 0;
  logic [SW-1:0] h0, h1, h2;
  wr_t           mw;
  res_t          mr;

  always @(negedge clk) begin
    if (reset) begin
      pb   = 1'b0;
      blen = 0;
    end else begin
      if (gf.mem_we) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          mw = wr_q.pop_front();
          check("wr_addr", 64'(gf.mem_addr), 64'(mw.a));
          check("wr_data", 64'(gf.mem_wdata), 64'(mw.d));
        end
      end
      if (gf.busy) begin
        if (!pb) begin
          h0 = gf.best0;
          h1 = gf.best1;
          h2 = gf.best2;
        end else begin
          check("best_hold", {gf.best0, gf.best1, gf.best2},
                {h0, h1, h2});
        end
        blen++;
      end else if (pb) begin
        if (res_q.size() == 0) begin
          check("unexpected_scan", 1, 0);
        end else begin
          mr = res_q.pop_front();
          check("busy_len", 64'(blen), 64'(mr.len));
          check("best0", 64'(gf.best0), 64'(mr.b0));
          check("best1", 64'(gf.best1), 64'(mr.b1));
          check("best2", 64'(gf.best2), 64'(mr.b2));
          check("over_after_scan", 64'(gf.game_over), 1);
        end
        blen = 0;
      end
      pb = gf.busy;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic flush_model();
    wr_q.delete();
    res_q.delete();
    mptr   = 0;
    mvalid = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    flush_model();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic play_game(input int sc, input int len,
                           input bit abort);
    gf.start = 1'b1;
    #1;
    check("obs_load_early", 64'(gf.obs_load), 0);
    step();
    check("obs_load", 64'(gf.obs_load), 1);
    check("load_not_playing", 64'(gf.playing), 0);
    gf.start = 1'b0;
    step();
    for (int i = 0; i < len; i++) begin
      check("playing", 64'(gf.playing), 1);
      check("game_tick", 64'(gf.game_tick),
            64'((i % TD) == TD - 1));
      step();
    end
    gf.score     = SW'(sc);
    gf.collision = 1'b1;
    expect_game(sc);
    #1;
    check("tick_at_collision", 64'(gf.game_tick), 0);
    step();
    gf.collision = 1'b0;
    if (abort) begin
      step();
      step();
      check("in_scan", 64'(gf.busy), 1);
      reset = 1'b1;
      #1;
      check("rst_we", 64'(gf.mem_we), 0);
      check("rst_busy", 64'(gf.busy), 0);
      check("rst_bests", {gf.best0, gf.best1, gf.best2}, 0);
      check("rst_over", 64'(gf.game_over), 0);
      flush_model();
      step();
      reset = 1'b0;
      step();
      check("idle_after_rst", 64'(gf.playing), 0);
    end else begin
      for (int k = 0; k < 80 && !gf.game_over; k++) step();
      check("reach_over", 64'(gf.game_over), 1);
    end
  endtask

  task automatic finish_over(input bit pulse);
    for (int c = 1; c <= OH * TD; c++) begin
      step();
      check("over_no_tick", 64'(gf.game_tick), 0);
      if (pulse && (c == 3 || c == 6)) gf.start = 1'b1;
      if (pulse && (c == 4 || c == 7)) begin
        check("start_ignored", 64'(gf.obs_load), 0);
        check("still_over", 64'(gf.game_over), 1);
        gf.start = 1'b0;
      end
    end
  endtask

  initial begin
    gf.start     = 1'b0;
    gf.collision = 1'b0;
    gf.score     = '0;
    for (int i = 0; i < DEPTH; i++)
      ram[i] = SW'($urandom_range(100, 2000));
    step();
    check("rst_tick", 64'(gf.game_tick), 0);
    check("rst_load", 64'(gf.obs_load), 0);
    check("rst_play", 64'(gf.playing), 0);
    check("rst_gover", 64'(gf.game_over), 0);
    check("rst_busy0", 64'(gf.busy), 0);
    check("rst_we0", 64'(gf.mem_we), 0);
    check("rst_addr", 64'(gf.mem_addr), 0);
    check("rst_best", {gf.best0, gf.best1, gf.best2}, 0);
    reset = 1'b0;
    step();

    play_game(7, 11, 1'b0);
    check("g1_best0", 64'(gf.best0), 7);
    check("g1_best1", 64'(gf.best1), 0);
    check("g1_best2", 64'(gf.best2), 0);
    finish_over(1'b1);

    do_reset();
    play_game(5, 2, 1'b0);
    finish_over(1'b0);
    play_game(9, 3, 1'b0);
    finish_over(1'b0);
    play_game(9, 5, 1'b0);
    check("g3_best0", 64'(gf.best0), 9);
    check("g3_best1", 64'(gf.best1), 9);
    check("g3_best2", 64'(gf.best2), 5);
    finish_over(1'b1);

    play_game(12, 4, 1'b1);

    for (int s = 1; s <= 33; s++) begin
      play_game(s, s % 5, 1'b0);
      finish_over(1'b0);
    end
    check("g33_best0", 64'(gf.best0), 33);
    check("g33_best1", 64'(gf.best1), 32);
    check("g33_best2", 64'(gf.best2), 31);
    check("wr_q_empty", 64'(wr_q.size()), 0);
    check("res_q_empty", 64'(res_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
